// File: rtl/uninasoc_pkg.sv
// Shared SoC package: GPIO-out register offsets, AXI response codes and FSM state types.
// GPIO_OUT_SETCLR_EN adds the SET/CLEAR aliases to the GPIO-out address decode.
package uninasoc_pkg;

   localparam logic [11:0] GPIO_OUT_DATA_OFFSET  = 12'h000;
   localparam logic [11:0] GPIO_OUT_SET_OFFSET   = 12'h004;
   localparam logic [11:0] GPIO_OUT_CLEAR_OFFSET = 12'h008;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_WAIT_W  = 2'd1,
      W_WAIT_AW = 2'd2,
      W_RESP    = 2'd3
   } gpio_out_wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } gpio_out_rd_state_e;

   // Word index (addr[11:2]) is a mapped register in the current build.
   function automatic logic gpio_out_offset_ok(input logic [9:0] idx);
`ifdef GPIO_OUT_SETCLR_EN
      return (idx == GPIO_OUT_DATA_OFFSET[11:2]) ||
             (idx == GPIO_OUT_SET_OFFSET[11:2])  ||
             (idx == GPIO_OUT_CLEAR_OFFSET[11:2]);
`else
      return (idx == GPIO_OUT_DATA_OFFSET[11:2]);
`endif
   endfunction

endpackage

// File: rtl/gpio_out_regs.sv
// GPIO-out DATA register with byte-strobed writes and optional atomic SET/CLEAR
// updates (GPIO_OUT_SETCLR_EN).
module gpio_out_regs
   import uninasoc_pkg::*;
#(
   parameter int unsigned NUM_GPIO    = 8,
   parameter logic [31:0] RESET_VALUE = '0
) (
   input  logic                clock_i,
   input  logic                reset_ni,
   input  logic                commit_i,
   input  logic [9:0]          offset_i,
   input  logic [31:0]         wdata_i,
   input  logic [3:0]          wstrb_i,
   output logic [NUM_GPIO-1:0] data_o
);

   logic [NUM_GPIO-1:0] data_q, data_d;
   logic [31:0]         byte_mask;
   logic [NUM_GPIO-1:0] mask;
   logic [NUM_GPIO-1:0] wval;
   logic                unused_upper;

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign byte_mask[gi*8 +: 8] = {8{wstrb_i[gi]}};
   end

   // Only the implemented pin bits take part in any update.
   assign mask         = byte_mask[NUM_GPIO-1:0];
   assign wval         = wdata_i[NUM_GPIO-1:0];
   assign unused_upper = ^{wdata_i, byte_mask};

   always_comb begin
      data_d = data_q;
      if (commit_i) begin
         if (offset_i == GPIO_OUT_DATA_OFFSET[11:2]) begin
            data_d = (data_q & ~mask) | (wval & mask);
         end
`ifdef GPIO_OUT_SETCLR_EN
         else if (offset_i == GPIO_OUT_SET_OFFSET[11:2]) begin
            data_d = data_q | (wval & mask);
         end
         else if (offset_i == GPIO_OUT_CLEAR_OFFSET[11:2]) begin
            data_d = data_q & ~(wval & mask);
         end
`endif
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         data_q <= RESET_VALUE[NUM_GPIO-1:0];
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/axilite_gpio_out.sv
// AXI4-Lite slave driving GPIO output pins from a DATA register; independent
// single-outstanding write and read FSMs. GPIO_OUT_SETCLR_EN enables SET/CLEAR aliases.
module axilite_gpio_out
   import uninasoc_pkg::*;
#(
   parameter int unsigned NUM_GPIO    = 8,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter logic [31:0] RESET_VALUE = '0
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr_i,
   input  logic [2:0]            s_axi_awprot_i,
   input  logic                  s_axi_awvalid_i,
   output logic                  s_axi_awready_o,
   input  logic [31:0]           s_axi_wdata_i,
   input  logic [3:0]            s_axi_wstrb_i,
   input  logic                  s_axi_wvalid_i,
   output logic                  s_axi_wready_o,
   output logic [1:0]            s_axi_bresp_o,
   output logic                  s_axi_bvalid_o,
   input  logic                  s_axi_bready_i,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr_i,
   input  logic [2:0]            s_axi_arprot_i,
   input  logic                  s_axi_arvalid_i,
   output logic                  s_axi_arready_o,
   output logic [31:0]           s_axi_rdata_o,
   output logic [1:0]            s_axi_rresp_o,
   output logic                  s_axi_rvalid_o,
   input  logic                  s_axi_rready_i,
   output logic [NUM_GPIO-1:0]   gpio_out_o
);

   gpio_out_wr_state_e wr_state_q, wr_state_d;
   gpio_out_rd_state_e rd_state_q, rd_state_d;

   logic                ready_en_q;
   logic [9:0]          awoff_q, awoff_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic                aw_hs, w_hs, ar_hs, commit;
   logic [9:0]          cm_off, ar_off;
   logic [31:0]         cm_data;
   logic [3:0]          cm_strb;
   logic [NUM_GPIO-1:0] data;
   logic                unused_ok;

   // Readies stay low until the first edge after reset release.
   assign s_axi_awready_o = ready_en_q & ((wr_state_q == W_IDLE) | (wr_state_q == W_WAIT_AW));
   assign s_axi_wready_o  = ready_en_q & ((wr_state_q == W_IDLE) | (wr_state_q == W_WAIT_W));
   assign s_axi_bvalid_o  = (wr_state_q == W_RESP);
   assign s_axi_bresp_o   = bresp_q;
   assign s_axi_arready_o = ready_en_q & (rd_state_q == R_IDLE);
   assign s_axi_rvalid_o  = (rd_state_q == R_RESP);
   assign s_axi_rdata_o   = rdata_q;
   assign s_axi_rresp_o   = rresp_q;

   assign aw_hs  = s_axi_awvalid_i & s_axi_awready_o;
   assign w_hs   = s_axi_wvalid_i & s_axi_wready_o;
   assign ar_hs  = s_axi_arvalid_i & s_axi_arready_o;
   assign ar_off = s_axi_araddr_i[11:2];

   // A channel handshaking this cycle supplies its live value, otherwise the latched one.
   assign cm_off  = aw_hs ? s_axi_awaddr_i[11:2] : awoff_q;
   assign cm_data = w_hs ? s_axi_wdata_i : wdata_q;
   assign cm_strb = w_hs ? s_axi_wstrb_i : wstrb_q;

   assign unused_ok = ^{s_axi_awprot_i, s_axi_arprot_i, s_axi_awaddr_i, s_axi_araddr_i};

   always_comb begin
      wr_state_d = wr_state_q;
      awoff_d    = awoff_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      commit     = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end else if (aw_hs) begin
               awoff_d    = s_axi_awaddr_i[11:2];
               wr_state_d = W_WAIT_W;
            end else if (w_hs) begin
               wdata_d    = s_axi_wdata_i;
               wstrb_d    = s_axi_wstrb_i;
               wr_state_d = W_WAIT_AW;
            end
         end
         W_WAIT_W: begin
            if (w_hs) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_WAIT_AW: begin
            if (aw_hs) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi_bready_i) begin
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
      if (commit) begin
         bresp_d = gpio_out_offset_ok(cm_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
   end

   // Read data comes from the register flops, so a same-edge write is not yet visible.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rd_state_d = R_RESP;
               rresp_d    = gpio_out_offset_ok(ar_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
               rdata_d    = (ar_off == GPIO_OUT_DATA_OFFSET[11:2]) ? 32'(data) : 32'h0;
            end
         end
         R_RESP: begin
            if (s_axi_rready_i) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         ready_en_q <= 1'b0;
         awoff_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         ready_en_q <= 1'b1;
         awoff_q    <= awoff_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   gpio_out_regs #(
      .NUM_GPIO    (NUM_GPIO),
      .RESET_VALUE (RESET_VALUE)
   ) u_regs (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .commit_i (commit),
      .offset_i (cm_off),
      .wdata_i  (cm_data),
      .wstrb_i  (cm_strb),
      .data_o   (data)
   );

   assign gpio_out_o = data;

endmodule

// File: tb/tb_axilite_gpio_out.sv
// Randomized self-checking bench for axilite_gpio_out against a register-map model;
// the model follows GPIO_OUT_SETCLR_EN the same way the design build does.
module tb_axilite_gpio_out;

   localparam int          NG    = 8;
   localparam logic [31:0] RV    = 32'h0000_005A;
   localparam logic [31:0] GMASK = 32'h0000_00FF;
`ifdef GPIO_OUT_SETCLR_EN
   localparam bit SETCLR = 1'b1;
`else
   localparam bit SETCLR = 1'b0;
`endif

   logic          clock_i = 1'b0;
   logic          reset_ni;
   logic [31:0]   awaddr, araddr, wdata;
   logic [3:0]    wstrb;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;
   logic [NG-1:0] gpio;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] mdata;

   always #5 clock_i = ~clock_i;

   axilite_gpio_out #(
      .NUM_GPIO    (NG),
      .ADDR_WIDTH  (32),
      .RESET_VALUE (RV)
   ) dut (
      .clock_i         (clock_i),
      .reset_ni        (reset_ni),
      .s_axi_awaddr_i  (awaddr),
      .s_axi_awprot_i  (3'b000),
      .s_axi_awvalid_i (awvalid),
      .s_axi_awready_o (awready),
      .s_axi_wdata_i   (wdata),
      .s_axi_wstrb_i   (wstrb),
      .s_axi_wvalid_i  (wvalid),
      .s_axi_wready_o  (wready),
      .s_axi_bresp_o   (bresp),
      .s_axi_bvalid_o  (bvalid),
      .s_axi_bready_i  (bready),
      .s_axi_araddr_i  (araddr),
      .s_axi_arprot_i  (3'b000),
      .s_axi_arvalid_i (arvalid),
      .s_axi_arready_o (arready),
      .s_axi_rdata_o   (rdata),
      .s_axi_rresp_o   (rresp),
      .s_axi_rvalid_o  (rvalid),
      .s_axi_rready_i  (rready),
      .gpio_out_o      (gpio)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Register-map model: byte mask from strobes, word index from addr[11:2].
   function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [31:0] data,
                                            input logic [3:0] strb);
      logic [31:0] m;
      int          idx;
      idx = int'(addr[11:2]);
      for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? 8'hFF : 8'h00;
      if (idx == 0) begin
         mdata = ((mdata & ~m) | (data & m)) & GMASK;
         return 2'b00;
      end
      if (SETCLR && idx == 1) begin
         mdata = (mdata | (data & m)) & GMASK;
         return 2'b00;
      end
      if (SETCLR && idx == 2) begin
         mdata = mdata & ~(data & m);
         return 2'b00;
      end
      return 2'b10;
   endfunction

   task automatic mdl_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
      int idx;
      idx = int'(addr[11:2]);
      d = 32'h0;
      r = 2'b10;
      if (idx == 0) begin
         d = mdata;
         r = 2'b00;
      end else if (SETCLR && (idx == 1 || idx == 2)) begin
         r = 2'b00;
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // mode 0: AW and W together; 1: AW first, W after gap cycles; 2: W first, AW after gap.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int mode, input int gap, input int bdly);
      logic [1:0] er;
      int         n;
      n = 0;
      if (mode == 0) begin
         awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
         while (!(awready && wready) && n < 20) begin tick(); n++; end
         chk("wr_idle_ready", {awready, wready}, 2'b11);
         tick();
         awvalid = 1'b0; wvalid = 1'b0;
      end else if (mode == 1) begin
         awaddr = addr; awvalid = 1'b1;
         while (!awready && n < 20) begin tick(); n++; end
         chk("aw_ready", awready, 1);
         tick();
         awvalid = 1'b0;
         for (int i = 0; i <= gap; i++) begin
            chk("wait_w_ready", {awready, wready}, 2'b01);
            chk("wait_w_gpio", gpio, mdata);
            if (i < gap) tick();
         end
         wdata = data; wstrb = strb; wvalid = 1'b1;
         tick();
         wvalid = 1'b0;
      end else begin
         wdata = data; wstrb = strb; wvalid = 1'b1;
         while (!wready && n < 20) begin tick(); n++; end
         chk("w_ready", wready, 1);
         tick();
         wvalid = 1'b0;
         for (int i = 0; i <= gap; i++) begin
            chk("wait_aw_ready", {awready, wready}, 2'b10);
            chk("wait_aw_gpio", gpio, mdata);
            if (i < gap) tick();
         end
         awaddr = addr; awvalid = 1'b1;
         tick();
         awvalid = 1'b0;
      end
      er = mdl_write(addr, data, strb);
      chk("bvalid", bvalid, 1);
      chk("bresp", bresp, er);
      chk("gpio_after_write", gpio, mdata);
      for (int i = 0; i < bdly; i++) begin
         tick();
         chk("bvalid_hold", bvalid, 1);
         chk("bresp_hold", bresp, er);
         chk("busy_ready", {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bvalid_clear", bvalid, 0);
      chk("gpio_stable", gpio, mdata);
      $display("WR addr=%h data=%h strb=%h mode=%0d resp=%0d gpio=%h", addr, data, strb, mode, er, gpio);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int rdly);
      logic [31:0] ed;
      logic [1:0]  er;
      int          n;
      n = 0;
      mdl_read(addr, ed, er);
      araddr = addr; arvalid = 1'b1;
      while (!arready && n < 20) begin tick(); n++; end
      chk("ar_ready", arready, 1);
      tick();
      arvalid = 1'b0;
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, ed);
      chk("rresp", rresp, er);
      for (int i = 0; i < rdly; i++) begin
         tick();
         chk("rvalid_hold", rvalid, 1);
         chk("rdata_hold", rdata, ed);
         chk("rresp_hold", rresp, er);
         chk("ar_busy", arready, 0);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rvalid_clear", rvalid, 0);
      $display("RD addr=%h rdata=%h resp=%0d", addr, rdata, rresp);
   endtask

   initial begin : main
      logic [31:0] old_data, addr, base;
      logic [1:0]  er;
      logic [31:0] bases [8];

      bases = '{32'h000, 32'h004, 32'h008, 32'h010, 32'h00C, 32'hFFC, 32'h1000, 32'h004};
      reset_ni = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      mdata = RV & GMASK;
      repeat (3) tick();

      // Reset state
      chk("rst_ready", {awready, wready, arready}, 3'b000);
      chk("rst_valid", {bvalid, rvalid}, 2'b00);
      chk("rst_resp", {bresp, rresp}, 4'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_gpio", gpio, mdata);
      reset_ni = 1'b1;
      chk("rel_ready_low", {awready, wready, arready}, 3'b000);
      tick();
      chk("idle_ready", {awready, wready, arready}, 3'b111);

      // Directed sequence
      axi_read(32'h000, 0);
      axi_write(32'h000, 32'h0000_00A5, 4'h1, 0, 0, 0);
      axi_write(32'h000, 32'h0000_003C, 4'hF, 1, 3, 4);
      axi_write(32'h000, 32'h0000_0081, 4'hF, 2, 2, 4);
      axi_write(32'h000, 32'h0000_00F0, 4'hF, 0, 0, 0);
      axi_write(32'h004, 32'h0000_000F, 4'hF, 0, 0, 1);
      axi_read(32'h000, 1);
      axi_write(32'h008, 32'h0000_003C, 4'hF, 0, 0, 0);
      axi_read(32'h000, 0);
      axi_read(32'h004, 0);
      axi_read(32'h008, 2);
      axi_write(32'h010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      axi_read(32'h010, 0);
      axi_write(32'h000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
      axi_write(32'h000, 32'h0000_FF00, 4'h2, 1, 0, 0);
      axi_write(32'hFFFF_F003, 32'h0000_0066, 4'h1, 2, 0, 0);

      // Write commit and read address on the same edge: read sees pre-write DATA
      old_data = mdata;
      awaddr = 32'h0; wdata = 32'h0000_0099; wstrb = 4'hF; araddr = 32'h0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      er = mdl_write(32'h0, 32'h0000_0099, 4'hF);
      chk("rw_bvalid", bvalid, 1);
      chk("rw_rvalid", rvalid, 1);
      chk("rw_rdata_old", rdata, old_data);
      chk("rw_gpio_new", gpio, mdata);
      chk("rw_bresp", bresp, er);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      chk("rw_clear", {bvalid, rvalid}, 2'b00);
      $display("RW same-edge old=%h new=%h", old_data, mdata);

      // Reset while a write response is pending
      awaddr = 32'h0; wdata = 32'h0000_0011; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      er = mdl_write(32'h0, 32'h0000_0011, 4'hF);
      chk("pre_rst_bvalid", bvalid, 1);
      chk("pre_rst_gpio", gpio, mdata);
      #2 reset_ni = 1'b0;
      #1;
      mdata = RV & GMASK;
      chk("async_bvalid", bvalid, 0);
      chk("async_gpio", gpio, mdata);
      chk("async_ready", {awready, wready, arready}, 3'b000);
      tick();
      reset_ni = 1'b1;
      tick();
      chk("post_rst_ready", {awready, wready, arready}, 3'b111);
      $display("RST mid-response gpio=%h", gpio);
      axi_write(32'h000, 32'h0000_0042, 4'hF, 0, 0, 0);
      axi_read(32'h000, 0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         base = bases[$urandom_range(0, 7)];
         addr = base | ($urandom & 32'hFFFF_F003);
         if ($urandom_range(0, 1) == 0) begin
            axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                      $urandom_range(0, 3), $urandom_range(0, 3));
         end else begin
            axi_read(addr, $urandom_range(0, 3));
         end
      end
      axi_read(32'h000, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axilite_gpio_out.md
# axilite_gpio_out

AXI4-Lite slave that drives the SoC's general-purpose output pins. It sits directly downstream of the system AXI crossbar, on the GPIO-out slave port counted in `NUM_GPIO_OUT`. It holds a DATA register, with optional atomic SET and CLEAR aliases, and presents that register on `gpio_out_o`. Write and read channels each run an independent one-transaction-in-flight FSM.

## Interface
- `NUM_GPIO`, default 8: number of driven pins, range 1..32. Register bits at or above `NUM_GPIO` read 0 and ignore writes.
- `ADDR_WIDTH`, default 32: AXI address width.
- `RESET_VALUE`, default `'0`: DATA register value after reset.
- Data width is fixed at 32 bits.

Ports:
- `clock_i`  in  1  system clock.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `s_axi_awaddr_i`  in  ADDR_WIDTH;  `s_axi_awprot_i`  in  3 (ignored);  `s_axi_awvalid_i`  in  1;  `s_axi_awready_o`  out  1.
- `s_axi_wdata_i`  in  32;  `s_axi_wstrb_i`  in  4;  `s_axi_wvalid_i`  in  1;  `s_axi_wready_o`  out  1.
- `s_axi_bresp_o`  out  2;  `s_axi_bvalid_o`  out  1;  `s_axi_bready_i`  in  1.
- `s_axi_araddr_i`  in  ADDR_WIDTH;  `s_axi_arprot_i`  in  3 (ignored);  `s_axi_arvalid_i`  in  1;  `s_axi_arready_o`  out  1.
- `s_axi_rdata_o`  out  32;  `s_axi_rresp_o`  out  2;  `s_axi_rvalid_o`  out  1;  `s_axi_rready_i`  in  1.
- `gpio_out_o`  out  NUM_GPIO  pin outputs, driven directly from the DATA register flops.

## Operation
- Register map (offset = `addr[11:2]` word index; `addr[1:0]` ignored; bits above 11 ignored):
  - 0x000 DATA, RW.
  - 0x004 SET, WO: DATA |= mask.
  - 0x008 CLEAR, WO: DATA &= ~mask.
- Any other offset: SLVERR (2'b10). Writes to it have no effect; reads return 0.
- Byte strobes: the byte mask is `wstrb` expanded to 32 bits.
  - DATA write: only strobed bytes are replaced.
  - SET/CLEAR write: mask = `wdata` & byte mask.
- Reads of SET and CLEAR return 0 with OKAY.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
    - AW and W handshake in the same cycle: commit and go to W_RESP.
    - AW only: latch address, go to W_WAIT_W.
    - W only: latch data and strobe, go to W_WAIT_AW.
  - W_WAIT_W: awready=0, wready=1. On W handshake, commit and go to W_RESP.
  - W_WAIT_AW: awready=1, wready=0. On AW handshake, commit and go to W_RESP.
  - W_RESP: bvalid=1 with bresp held stable. On bready, go to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, register rdata and rresp, go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp are held stable until the rready handshake, then go to R_IDLE.
- Simultaneous write commit and AR handshake on the same edge: the read returns the pre-write DATA value.
- Reset mid-transaction: both FSMs return to idle, any pending response is dropped, DATA returns to `RESET_VALUE`.

## Timing
- Reset values:
  - awready=0, wready=0, arready=0 while `reset_ni` is low; each rises to 1 in the first cycle after reset release (idle state).
  - bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0.
  - `gpio_out_o` = `RESET_VALUE[NUM_GPIO-1:0]`.
- Write latency: DATA and `gpio_out_o` update on the edge that completes the later of the AW and W handshakes. bvalid is asserted in the following cycle, the same cycle the new pin value is visible.
- Read latency: rvalid is asserted in the cycle after the AR handshake.
- Back-to-back throughput: one write per 2 cycles with bready tied high; one read per 2 cycles with rready tied high.
- No combinational path from any input to any output.

## Configuration
- `GPIO_OUT_SETCLR_EN` defined: SET (0x004) and CLEAR (0x008) are implemented as described above.
- `GPIO_OUT_SETCLR_EN` undefined:
  - 0x004 and 0x008 decode as unmapped: SLVERR, no effect on write, 0 on read.
  - The set/clear logic is not synthesized.

## Structure
- Shared package `uninasoc_pkg` gains:
  - Offset constants `GPIO_OUT_DATA_OFFSET`, `GPIO_OUT_SET_OFFSET`, `GPIO_OUT_CLEAR_OFFSET`.
  - AXI response localparams `AXI_RESP_OKAY`, `AXI_RESP_SLVERR`.
  - The write/read FSM state enum typedefs.
- Sub-module `gpio_out_regs`: the DATA register plus strobe, set and clear update logic. It takes a commit pulse, offset, data and strobe, and returns the register value. The AXI FSMs stay in the top module.

## Test plan
- Reset, then read 0x000 → rdata=`RESET_VALUE`, rresp=OKAY, rvalid one cycle after AR; `gpio_out_o`=`RESET_VALUE`.
- AW and W in the same cycle: 0x000, wdata=0xA5, wstrb=0x1 → bvalid next cycle, OKAY; `gpio_out_o`=0xA5 in the bvalid cycle.
- AW three cycles before W, then W before AW, bready held low 4 cycles → awready/wready follow the FSM; bvalid and bresp stay stable until bready; no second write is accepted meanwhile.
- With DATA=0xF0: SET 0x0F → 0xFF; CLEAR 0x3C → 0xC3. Without `GPIO_OUT_SETCLR_EN`, both return SLVERR and DATA stays 0xF0.
- Write and read 0x010 → SLVERR on both channels, rdata=0, DATA unchanged.
- Assert `reset_ni` low while bvalid=1 → bvalid drops asynchronously; DATA=`RESET_VALUE`; the next transaction completes normally.
